mips_operand_fetch: RTL and testbench



---
 rtl/mips_operand_fetch.sv | 120 ++++++++++++
 tb/tb_mips_operand_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_operand_fetch.sv
// Decode/operand-fetch stage: reads rs/rt from a 32x32 register file (with write-back bypass)
// and holds the decoded R-type fields in a single output register for the ALU.
module mips_operand_fetch #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [5:0]    funct,
  output logic [4:0]    shamt,
  output logic [4:0]    rd_addr,
  output logic          illegal,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [15:0]   issued_cnt
);

  logic [DW-1:0] regs [NREGS];

  logic          out_valid_reg;
  logic [DW-1:0] rs_data_reg, rt_data_reg;
  logic [5:0]    funct_reg;
  logic [4:0]    shamt_reg, rd_addr_reg;
  logic          illegal_reg;
  logic [4:0]    rs_held_reg, rt_held_reg;
  logic [15:0]   issued_cnt_reg;

  logic          accept, consume, stall, wb_live;
  logic [4:0]    rs_idx, rt_idx;
  logic [DW-1:0] rs_next, rt_next;
  logic          illegal_next;

  assign rs_idx   = instr[25:21];
  assign rt_idx   = instr[20:16];
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;
  assign stall    = out_valid_reg && !out_ready;
  assign wb_live  = wb_en && (wb_addr != 5'd0);

  // Write-then-read bypass: a same-cycle write-back wins over the stored register value.
  always_comb begin
    rs_next = regs[rs_idx];
    rt_next = regs[rt_idx];
    if (rs_idx == 5'd0)                    rs_next = '0;
    else if (wb_live && wb_addr == rs_idx) rs_next = wb_data;
    if (rt_idx == 5'd0)                    rt_next = '0;
    else if (wb_live && wb_addr == rt_idx) rt_next = wb_data;
  end

  always_comb begin
    illegal_next = 1'b0;
    if (instr[31:26] != 6'd0) illegal_next = 1'b1;
    else begin
      case (instr[5:0])
        6'h21, 6'h23, 6'h00, 6'h04: illegal_next = 1'b0;
        default:                    illegal_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      funct_reg      <= '0;
      shamt_reg      <= '0;
      rd_addr_reg    <= '0;
      illegal_reg    <= 1'b0;
      rs_held_reg    <= '0;
      rt_held_reg    <= '0;
      issued_cnt_reg <= '0;
    end else begin
      if (consume) issued_cnt_reg <= issued_cnt_reg + 16'd1;
      if (accept) begin
        out_valid_reg <= 1'b1;
        rs_data_reg   <= rs_next;
        rt_data_reg   <= rt_next;
        funct_reg     <= instr[5:0];
        shamt_reg     <= instr[10:6];
        rd_addr_reg   <= instr[15:11];
        illegal_reg   <= illegal_next;
        rs_held_reg   <= rs_idx;
        rt_held_reg   <= rt_idx;
      end else begin
        if (consume) out_valid_reg <= 1'b0;
        // Stalled operands track write-backs so the ALU never sees a stale value.
        if (stall && wb_live && wb_addr == rs_held_reg) rs_data_reg <= wb_data;
        if (stall && wb_live && wb_addr == rt_held_reg) rt_data_reg <= wb_data;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign rs_data    = rs_data_reg;
  assign rt_data    = rt_data_reg;
  assign funct      = funct_reg;
  assign shamt      = shamt_reg;
  assign rd_addr    = rd_addr_reg;
  assign illegal    = illegal_reg;
  assign issued_cnt = issued_cnt_reg;

endmodule

// File: tb/tb_mips_operand_fetch.sv
// Directed bench for mips_operand_fetch: a behavioural model checked every cycle,
// plus hand-computed literal expectations at key points of the sequence.
module tb_mips_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, illegal, wb_en;
  logic [31:0] instr, rs_data, rt_data, wb_data;
  logic [5:0]  funct;
  logic [4:0]  shamt, rd_addr, wb_addr;
  logic [15:0] issued_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mips_operand_fetch #(.NREGS(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .rs_data(rs_data), .rt_data(rt_data),
    .funct(funct), .shamt(shamt), .rd_addr(rd_addr), .illegal(illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register file plus the one held instruction.
  int unsigned m_regs [32];
  bit          m_valid = 0;
  int unsigned m_rs = 0, m_rt = 0, m_cnt = 0;
  int unsigned m_src_rs = 0, m_src_rt = 0, m_funct = 0, m_shamt = 0, m_rd = 0;
  bit          m_illegal = 0;

  function automatic int unsigned read_src(int unsigned src);
    if (src == 0) return 0;
    if (wb_en && wb_addr == src) return wb_data;
    return m_regs[src];
  endfunction

  always @(posedge clk) begin
    bit acc, cons, stalled;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_valid = 0; m_rs = 0; m_rt = 0; m_cnt = 0;
      m_src_rs = 0; m_src_rt = 0; m_funct = 0; m_shamt = 0; m_rd = 0; m_illegal = 0;
    end else begin
      acc     = in_valid && (!m_valid || out_ready);
      cons    = m_valid && out_ready;
      stalled = m_valid && !out_ready;
      if (cons) m_cnt = (m_cnt + 1) % 65536;
      if (acc) begin
        m_src_rs  = instr[25:21];
        m_src_rt  = instr[20:16];
        m_rs      = read_src(m_src_rs);
        m_rt      = read_src(m_src_rt);
        m_funct   = instr[5:0];
        m_shamt   = instr[10:6];
        m_rd      = instr[15:11];
        m_illegal = !(instr[31:26] == 0 && instr[5:0] inside {6'h21, 6'h23, 6'h00, 6'h04});
        m_valid   = 1;
      end else if (cons) begin
        m_valid = 0;
      end
      if (stalled && wb_en && wb_addr != 0) begin
        if (wb_addr == m_src_rs) m_rs = wb_data;
        if (wb_addr == m_src_rt) m_rt = wb_data;
      end
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    chk("out_valid",  {31'd0, out_valid}, {31'd0, m_valid});
    chk("in_ready",   {31'd0, in_ready},  {31'd0, (!m_valid || out_ready)});
    chk("issued_cnt", {16'd0, issued_cnt}, m_cnt);
    chk("rs_data",    rs_data, m_rs);
    chk("rt_data",    rt_data, m_rt);
    chk("funct",      {26'd0, funct},   m_funct);
    chk("shamt",      {27'd0, shamt},   m_shamt);
    chk("rd_addr",    {27'd0, rd_addr}, m_rd);
    chk("illegal",    {31'd0, illegal}, {31'd0, m_illegal});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wb_en = 0; out_ready = 1;
    tick();
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1; instr = ins;
    tick();
    in_valid = 0;
    $display("issue instr=0x%08h rs=0x%08h rt=0x%08h funct=0x%02h rd=%0d ill=%0b cnt=%0d",
             ins, rs_data, rt_data, funct, rd_addr, illegal, issued_cnt);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 0;
    $display("wb $%0d <= 0x%08h", a, d);
  endtask

  initial begin
    rst = 1; in_valid = 0; instr = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
    tick(); tick();
    rst = 0;
    chk("lit_reset_valid", {31'd0, out_valid}, 0);
    chk("lit_reset_ready", {31'd0, in_ready}, 1);
    chk("lit_reset_cnt",   {16'd0, issued_cnt}, 0);

    issue(32'h00221821);                       // ADDU $3,$1,$2 on a cleared file
    chk("lit_addu0_rs", rs_data, 0);
    chk("lit_addu0_rt", rt_data, 0);
    chk("lit_addu0_funct", {26'd0, funct}, 32'h21);
    chk("lit_addu0_rd", {27'd0, rd_addr}, 3);
    chk("lit_addu0_ill", {31'd0, illegal}, 0);

    wb(5'd1, 32'd10);                          // also consumes the first ADDU
    wb(5'd2, 32'd20);
    issue(32'h00221821);
    chk("lit_addu1_rs", rs_data, 10);
    chk("lit_addu1_rt", rt_data, 20);
    wb(5'd3, rs_data + rt_data);               // ALU result loop-back
    issue(32'h00603821);                       // ADDU $7,$3,$0 reads back Reg[3]
    chk("lit_reg3", rs_data, 30);
    idle();

    wb_en = 1; wb_addr = 5'd1; wb_data = 32'd30;
    issue(32'h00222023);                       // SUBU $4,$1,$2 with same-cycle write to $1
    wb_en = 0;
    chk("lit_bypass_rs", rs_data, 30);
    chk("lit_bypass_funct", {26'd0, funct}, 32'h23);

    wb(5'd0, 32'hDEAD);
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hBEEF;
    issue(32'h00011021);                       // ADDU $2,$0,$1 with a write to $0 in flight
    wb_en = 0;
    chk("lit_r0_rs", rs_data, 0);
    chk("lit_r0_rt", rt_data, 30);
    idle();

    out_ready = 0;
    issue(32'h00412804);                       // SLLV $5: rs=$2, rt=$1
    chk("lit_stall_ready", {31'd0, in_ready}, 0);
    tick();
    wb(5'd1, 32'd2);                           // refresh the held rt operand
    tick();
    chk("lit_refresh_rt", rt_data, 2);
    chk("lit_refresh_rs", rs_data, 20);
    chk("lit_refresh_valid", {31'd0, out_valid}, 1);
    out_ready = 1;
    tick();
    chk("lit_stall_cnt", {16'd0, issued_cnt}, 6);
    chk("lit_stall_drained", {31'd0, out_valid}, 0);

    out_ready = 1;
    issue(32'h00221821);
    chk("lit_b2b_funct0", {26'd0, funct}, 32'h21);
    issue(32'h00053080);                       // SLL $6,$0,$5 shamt=2
    chk("lit_b2b_valid1", {31'd0, out_valid}, 1);
    chk("lit_b2b_shamt", {27'd0, shamt}, 2);
    chk("lit_b2b_rd", {27'd0, rd_addr}, 6);
    issue(32'h00222023);
    chk("lit_b2b_rs2", rs_data, 2);
    issue(32'h00603821);
    chk("lit_b2b_rs3", rs_data, 30);
    idle();
    chk("lit_b2b_cnt", {16'd0, issued_cnt}, 10);

    out_ready = 0;
    issue(32'h8C220000);                       // lw is not a supported R-type
    chk("lit_lw_ill", {31'd0, illegal}, 1);
    chk("lit_lw_funct", {26'd0, funct}, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("lit_rst_valid", {31'd0, out_valid}, 0);
    chk("lit_rst_cnt", {16'd0, issued_cnt}, 0);
    out_ready = 1;
    issue(32'h00221821);
    chk("lit_rst_rs", rs_data, 0);
    chk("lit_rst_rt", rt_data, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
